// File: rtl/common_p.sv
// Shared types for the clock-recovery path: clock/reset bundle and the
// lock state encoding consumed by the downstream recovery controller.
package common_p;

  // Single clock domain: clock plus synchronous active-low reset.
  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;

  // Lock state as reported on state_o.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } lock_state_e;

endpackage

// File: rtl/lock_confidence_controller_counter.sv
// decaying_saturation_counter: a counter that grows by a rate up to a
// ceiling and decays by a rate down to a floor. The floor is the plateau
// value when plateau_en_i is high, otherwise the decay rate itself.
// Priority: clear, init, increment, decay, hold.
module decaying_saturation_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clear_i,
  input  logic         init_i,
  input  logic [W-1:0] init_value_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         plateau_en_i,
  input  logic [W-1:0] plateau_i,
  input  logic [W-1:0] growth_i,
  input  logic [W-1:0] decay_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] floor_s;
  logic [W-1:0] diff_s;
  logic [W:0]   sum_s;

  // Next-count selection: saturating growth, floored decay, clear first.
  always_comb begin
    floor_s = plateau_en_i ? plateau_i : decay_i;
    sum_s   = {1'b0, count_q} + {1'b0, growth_i};
    diff_s  = count_q - decay_i;
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (init_i) begin
      count_d = init_value_i;
    end else if (inc_i) begin
      if (sum_s > {1'b0, limit_i}) begin
        count_d = limit_i;
      end else begin
        count_d = sum_s[W-1:0];
      end
    end else if (dec_i) begin
      if (count_q <= floor_s) begin
        count_d = count_q;
      end else if ((count_q < decay_i) || (diff_s < floor_s)) begin
        count_d = floor_s;
      end else begin
        count_d = diff_s;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lock_confidence_controller.sv
// lock_confidence_controller: sequences one decaying saturation counter as
// a lock-confidence metric. Hit samples grow confidence, misses decay it,
// with rates chosen by the registered lock state. Reports state, lock and
// unlock events and the confidence value, all registered.
// Optional feature macro: LOCK_CTRL_HOLDOVER_EN adds the HOLDOVER state,
// its timer and the holdover_cycles_i port; without it LOCKED falls
// straight back to ACQUIRE.
module lock_confidence_controller
  import common_p::*;
#(
  parameter int unsigned BIT_WIDTH = 8
`ifdef LOCK_CTRL_HOLDOVER_EN
  , parameter int unsigned HOLDOVER_WIDTH = 16
`endif
) (
  input  common_p::clk_dom_s     sys_dom_i,
  input  logic                   enable_i,
  input  logic                   sample_valid_i,
  input  logic                   sample_hit_i,
  input  logic [BIT_WIDTH-1:0]   acq_growth_i,
  input  logic [BIT_WIDTH-1:0]   acq_decay_i,
  input  logic [BIT_WIDTH-1:0]   lock_growth_i,
  input  logic [BIT_WIDTH-1:0]   lock_decay_i,
  input  logic [BIT_WIDTH-1:0]   lock_threshold_i,
  input  logic [BIT_WIDTH-1:0]   unlock_threshold_i,
  input  logic [BIT_WIDTH-1:0]   saturation_limit_i,
`ifdef LOCK_CTRL_HOLDOVER_EN
  input  logic [HOLDOVER_WIDTH-1:0] holdover_cycles_i,
`endif
  output logic [1:0]             state_o,
  output logic                   locked_o,
  output logic                   lock_event_o,
  output logic                   unlock_event_o,
  output logic [BIT_WIDTH-1:0]   confidence_o
);

  logic clk_s;
  logic rst_n_s;
  assign clk_s   = sys_dom_i.clk;
  assign rst_n_s = sys_dom_i.rst_n;

  lock_state_e          state_q;
  logic                 locked_q;
  logic                 lock_event_q;
  logic                 unlock_event_q;
  logic [BIT_WIDTH-1:0] conf_s;
  logic [BIT_WIDTH-1:0] growth_s;
  logic [BIT_WIDTH-1:0] decay_s;
  logic                 clear_s;
  logic                 inc_s;
  logic                 dec_s;
  logic                 sample_ok_s;

`ifdef LOCK_CTRL_HOLDOVER_EN
  logic [HOLDOVER_WIDTH-1:0] timer_q;
  logic [HOLDOVER_WIDTH-1:0] timer_load_s;
  // Holdover length is at least one cycle even when programmed to zero.
  assign timer_load_s = (holdover_cycles_i == '0) ? HOLDOVER_WIDTH'(1) : holdover_cycles_i;
`endif

  // Rate selection from the registered state and counter control decode.
  always_comb begin
    if (state_q == LOCKED) begin
      growth_s = lock_growth_i;
      decay_s  = lock_decay_i;
    end else begin
      growth_s = acq_growth_i;
      decay_s  = acq_decay_i;
    end
    clear_s     = (state_q == IDLE);
    sample_ok_s = enable_i & sample_valid_i & (state_q != IDLE);
    inc_s       = sample_ok_s & sample_hit_i;
    dec_s       = sample_ok_s & ~sample_hit_i;
  end

  decaying_saturation_counter #(
    .W (BIT_WIDTH)
  ) u_counter (
    .clk_i        (clk_s),
    .rst_n_i      (rst_n_s),
    .clear_i      (clear_s),
    .init_i       (1'b0),
    .init_value_i ({BIT_WIDTH{1'b0}}),
    .inc_i        (inc_s),
    .dec_i        (dec_s),
    .plateau_en_i (1'b0),
    .plateau_i    ({BIT_WIDTH{1'b0}}),
    .growth_i     (growth_s),
    .decay_i      (decay_s),
    .limit_i      (saturation_limit_i),
    .count_o      (conf_s)
  );

  // Lock FSM with registered lock flag and one-cycle event pulses;
  // a low enable overrides every other transition.
  always_ff @(posedge clk_s) begin
    if (!rst_n_s) begin
      state_q        <= IDLE;
      locked_q       <= 1'b0;
      lock_event_q   <= 1'b0;
      unlock_event_q <= 1'b0;
`ifdef LOCK_CTRL_HOLDOVER_EN
      timer_q        <= '0;
`endif
    end else begin
      lock_event_q   <= 1'b0;
      unlock_event_q <= 1'b0;
      if (!enable_i) begin
        state_q        <= IDLE;
        locked_q       <= 1'b0;
        unlock_event_q <= (state_q == LOCKED) || (state_q == HOLDOVER);
      end else begin
        case (state_q)
          IDLE: begin
            state_q  <= ACQUIRE;
            locked_q <= 1'b0;
          end
          ACQUIRE: begin
            if (conf_s >= lock_threshold_i) begin
              state_q      <= LOCKED;
              locked_q     <= 1'b1;
              lock_event_q <= 1'b1;
            end else begin
              locked_q <= 1'b0;
            end
          end
          LOCKED: begin
            if (conf_s < unlock_threshold_i) begin
`ifdef LOCK_CTRL_HOLDOVER_EN
              state_q  <= HOLDOVER;
              locked_q <= 1'b1;
              timer_q  <= timer_load_s;
`else
              state_q        <= ACQUIRE;
              locked_q       <= 1'b0;
              unlock_event_q <= 1'b1;
`endif
            end else begin
              locked_q <= 1'b1;
            end
          end
`ifdef LOCK_CTRL_HOLDOVER_EN
          HOLDOVER: begin
            if (conf_s >= lock_threshold_i) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else if (timer_q <= HOLDOVER_WIDTH'(1)) begin
              state_q        <= ACQUIRE;
              locked_q       <= 1'b0;
              unlock_event_q <= 1'b1;
              timer_q        <= '0;
            end else begin
              locked_q <= 1'b1;
              timer_q  <= timer_q - HOLDOVER_WIDTH'(1);
            end
          end
`endif
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_o        = state_q;
  assign locked_o       = locked_q;
  assign lock_event_o   = lock_event_q;
  assign unlock_event_o = unlock_event_q;
  assign confidence_o   = conf_s;

endmodule

// File: tb/tb_lock_confidence_controller.sv
// Self-checking bench for lock_confidence_controller: directed scenarios
// from the test plan plus randomized traffic against a behavioural model.
module tb_lock_confidence_controller;
  import common_p::*;

  logic       clk;
  logic       rst_n;
  clk_dom_s   sys_dom;
  logic       enable, sample_valid, sample_hit;
  logic [7:0] acq_growth, acq_decay, lock_growth, lock_decay;
  logic [7:0] lock_th, unlock_th, sat_lim;
`ifdef LOCK_CTRL_HOLDOVER_EN
  logic [15:0] hold_cycles;
`endif
  logic [1:0] state_o;
  logic       locked_o, lock_event_o, unlock_event_o;
  logic [7:0] confidence_o;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state (plain integers, spec-level rules).
  int m_state = 0, m_conf = 0, m_hold_len = 0, m_hold_cnt = 0;
  bit m_lev = 0, m_uev = 0;

  assign sys_dom = '{clk: clk, rst_n: rst_n};

  lock_confidence_controller dut (
    .sys_dom_i          (sys_dom),
    .enable_i           (enable),
    .sample_valid_i     (sample_valid),
    .sample_hit_i       (sample_hit),
    .acq_growth_i       (acq_growth),
    .acq_decay_i        (acq_decay),
    .lock_growth_i      (lock_growth),
    .lock_decay_i       (lock_decay),
    .lock_threshold_i   (lock_th),
    .unlock_threshold_i (unlock_th),
    .saturation_limit_i (sat_lim),
`ifdef LOCK_CTRL_HOLDOVER_EN
    .holdover_cycles_i  (hold_cycles),
`endif
    .state_o            (state_o),
    .locked_o           (locked_o),
    .lock_event_o       (lock_event_o),
    .unlock_event_o     (unlock_event_o),
    .confidence_o       (confidence_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: predict next outputs from current inputs, then advance.
  task automatic cyc();
    int g, d, nc, ns, nhl, nhc, hl;
    bit le, ue;
    g  = (m_state == 2) ? int'(lock_growth) : int'(acq_growth);
    d  = (m_state == 2) ? int'(lock_decay)  : int'(acq_decay);
    nc = m_conf;
    if (m_state == 0) nc = 0;
    else if (enable && sample_valid) begin
      if (sample_hit) nc = (m_conf + g > int'(sat_lim)) ? int'(sat_lim) : m_conf + g;
      else if (m_conf > d) nc = (m_conf - d < d) ? d : m_conf - d;
    end
    ns = m_state; le = 0; ue = 0; nhl = m_hold_len; nhc = m_hold_cnt;
    hl = 1;
`ifdef LOCK_CTRL_HOLDOVER_EN
    hl = (hold_cycles == 16'd0) ? 1 : int'(hold_cycles);
`endif
    if (!enable) begin
      ns = 0; ue = (m_state >= 2);
    end else if (m_state == 0) ns = 1;
    else if (m_state == 1) begin
      if (m_conf >= int'(lock_th)) begin ns = 2; le = 1; end
    end else if (m_state == 2) begin
      if (m_conf < int'(unlock_th)) begin
`ifdef LOCK_CTRL_HOLDOVER_EN
        ns = 3; nhl = hl; nhc = 0;
`else
        ns = 1; ue = 1;
`endif
      end
    end else begin
      if (m_conf >= int'(lock_th)) ns = 2;
      else begin
        nhc = m_hold_cnt + 1;
        if (nhc >= m_hold_len) begin ns = 1; ue = 1; end
      end
    end
    @(posedge clk); #1;
    if (!rst_n) begin
      m_state = 0; m_conf = 0; m_lev = 0; m_uev = 0; m_hold_len = 0; m_hold_cnt = 0;
    end else begin
      m_state = ns; m_conf = nc; m_lev = le; m_uev = ue; m_hold_len = nhl; m_hold_cnt = nhc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_hit = 1'b0;
    cyc(); cyc();
    n_total++; if (state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_o); else n_pass++;
    n_total++; if (locked_o !== 1'b0) $display("FAIL reset_locked: got %0d want 0", locked_o); else n_pass++;
    n_total++; if (lock_event_o !== 1'b0) $display("FAIL reset_lev: got %0d want 0", lock_event_o); else n_pass++;
    n_total++; if (unlock_event_o !== 1'b0) $display("FAIL reset_uev: got %0d want 0", unlock_event_o); else n_pass++;
    n_total++; if (confidence_o !== 8'd0) $display("FAIL reset_conf: got %0d want 0", confidence_o); else n_pass++;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_acquire();
    enable = 1'b1;
    cyc();
    n_total++; if (state_o !== 2'd1) $display("FAIL acq_enter: got %0d want 1", state_o); else n_pass++;
    sample_valid = 1'b1; sample_hit = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      n_total++; if (confidence_o !== 8'(4 * k)) $display("FAIL acq_conf: hit %0d got %0d want %0d", k, confidence_o, 4 * k); else n_pass++;
    end
    n_total++; if (state_o !== 2'd1) $display("FAIL acq_not_yet: got %0d want 1", state_o); else n_pass++;
    sample_valid = 1'b0;
    cyc();
    n_total++; if (state_o !== 2'd2) $display("FAIL acq_locked_state: got %0d want 2", state_o); else n_pass++;
    n_total++; if (locked_o !== 1'b1) $display("FAIL acq_locked: got %0d want 1", locked_o); else n_pass++;
    n_total++; if (lock_event_o !== 1'b1) $display("FAIL acq_lev: got %0d want 1", lock_event_o); else n_pass++;
    cyc();
    n_total++; if (lock_event_o !== 1'b0) $display("FAIL acq_lev_once: got %0d want 0", lock_event_o); else n_pass++;
  endtask

  task automatic test_saturation();
    sample_valid = 1'b1; sample_hit = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      n_total++; if (confidence_o !== 8'((32 + k > 64) ? 64 : 32 + k)) $display("FAIL sat_conf: hit %0d got %0d want %0d", k, confidence_o, (32 + k > 64) ? 64 : 32 + k); else n_pass++;
    end
  endtask

  task automatic test_unlock();
    sample_valid = 1'b1; sample_hit = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      n_total++; if (confidence_o !== 8'(64 - 8 * k)) $display("FAIL unl_conf: miss %0d got %0d want %0d", k, confidence_o, 64 - 8 * k); else n_pass++;
      n_total++; if (state_o !== 2'd2) $display("FAIL unl_still_locked: miss %0d got %0d want 2", k, state_o); else n_pass++;
    end
    sample_valid = 1'b0;
    cyc();
`ifdef LOCK_CTRL_HOLDOVER_EN
    for (int k = 1; k <= 10; k++) begin
      n_total++; if (state_o !== 2'd3 || locked_o !== 1'b1) $display("FAIL hold_state: cycle %0d got %0d/%0d want 3/1", k, state_o, locked_o); else n_pass++;
      cyc();
    end
`endif
    n_total++; if (state_o !== 2'd1) $display("FAIL unl_state: got %0d want 1", state_o); else n_pass++;
    n_total++; if (unlock_event_o !== 1'b1) $display("FAIL unl_uev: got %0d want 1", unlock_event_o); else n_pass++;
    n_total++; if (locked_o !== 1'b0) $display("FAIL unl_locked: got %0d want 0", locked_o); else n_pass++;
    n_total++; if (confidence_o !== 8'd8) $display("FAIL unl_floor: got %0d want 8", confidence_o); else n_pass++;
    cyc();
    n_total++; if (unlock_event_o !== 1'b0) $display("FAIL unl_uev_once: got %0d want 0", unlock_event_o); else n_pass++;
  endtask

`ifdef LOCK_CTRL_HOLDOVER_EN
  task automatic test_holdover_relock();
    sample_valid = 1'b1; sample_hit = 1'b1;
    for (int k = 0; k < 20 && state_o !== 2'd2; k++) cyc();
    sample_hit = 1'b0;
    for (int k = 0; k < 20 && state_o !== 2'd3; k++) begin
      if (confidence_o < 8'd16) sample_valid = 1'b0;
      cyc();
    end
    n_total++; if (state_o !== 2'd3) $display("FAIL relock_enter: got %0d want 3", state_o); else n_pass++;
    sample_valid = 1'b1; sample_hit = 1'b1;
    for (int k = 0; k < 12 && state_o !== 2'd2; k++) begin
      cyc();
      n_total++; if (unlock_event_o !== 1'b0) $display("FAIL relock_no_pulse: got %0d want 0", unlock_event_o); else n_pass++;
    end
    n_total++; if (state_o !== 2'd2) $display("FAIL relock_state: got %0d want 2", state_o); else n_pass++;
    sample_valid = 1'b0;
    cyc();
  endtask
`endif

  task automatic test_enable_drop();
    int exp_conf;
    sample_valid = 1'b1; sample_hit = 1'b1;
    for (int k = 0; k < 20 && state_o !== 2'd2; k++) cyc();
    sample_valid = 1'b0;
    cyc();
    n_total++; if (state_o !== 2'd2) $display("FAIL drop_pre_locked: got %0d want 2", state_o); else n_pass++;
    exp_conf = m_conf;
    enable = 1'b0; sample_valid = 1'b1; sample_hit = 1'b1;
    cyc();
    n_total++; if (state_o !== 2'd0) $display("FAIL drop_state: got %0d want 0", state_o); else n_pass++;
    n_total++; if (unlock_event_o !== 1'b1) $display("FAIL drop_uev: got %0d want 1", unlock_event_o); else n_pass++;
    n_total++; if (confidence_o !== 8'(exp_conf)) $display("FAIL drop_hit_ignored: got %0d want %0d", confidence_o, exp_conf); else n_pass++;
    sample_valid = 1'b0;
    cyc();
    n_total++; if (confidence_o !== 8'd0) $display("FAIL drop_clear: got %0d want 0", confidence_o); else n_pass++;
    n_total++; if (unlock_event_o !== 1'b0) $display("FAIL drop_uev_once: got %0d want 0", unlock_event_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    cyc();
    sample_valid = 1'b1; sample_hit = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    n_total++; if (confidence_o !== 8'd20) $display("FAIL rmid_pre: got %0d want 20", confidence_o); else n_pass++;
    sample_valid = 1'b0; rst_n = 1'b0;
    cyc();
    n_total++; if ({state_o, locked_o, lock_event_o, unlock_event_o, confidence_o} !== 13'd0) $display("FAIL rmid_zero: got st=%0d conf=%0d want 0", state_o, confidence_o); else n_pass++;
    rst_n = 1'b1;
    cyc();
    n_total++; if (state_o !== 2'd1 || confidence_o !== 8'd0) $display("FAIL rmid_resume: got st=%0d conf=%0d want 1/0", state_o, confidence_o); else n_pass++;
    sample_valid = 1'b1;
    cyc();
    n_total++; if (confidence_o !== 8'd4) $display("FAIL rmid_first_hit: got %0d want 4", confidence_o); else n_pass++;
    sample_valid = 1'b0;
  endtask

  task automatic test_random();
    int hit_pct;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    for (int blk = 0; blk < 9; blk++) begin
      hit_pct = (blk % 3 == 0) ? 85 : ((blk % 3 == 1) ? 60 : 30);
`ifdef LOCK_CTRL_HOLDOVER_EN
      hold_cycles = 16'($urandom_range(0, 12));
`endif
      for (int c = 0; c < 100; c++) begin
        enable       = ($urandom_range(0, 99) >= 2);
        sample_valid = ($urandom_range(0, 99) < 75);
        sample_hit   = ($urandom_range(0, 99) < hit_pct);
        rst_n        = ($urandom_range(0, 199) != 0);
        cyc();
        n_total++; if (state_o !== 2'(m_state)) $display("FAIL rnd_state: cyc %0d got %0d want %0d", c, state_o, m_state); else n_pass++;
        n_total++; if (confidence_o !== 8'(m_conf)) $display("FAIL rnd_conf: cyc %0d got %0d want %0d", c, confidence_o, m_conf); else n_pass++;
        n_total++; if (locked_o !== (m_state >= 2)) $display("FAIL rnd_locked: cyc %0d got %0d want %0d", c, locked_o, m_state >= 2); else n_pass++;
        n_total++; if (lock_event_o !== m_lev) $display("FAIL rnd_lev: cyc %0d got %0d want %0d", c, lock_event_o, m_lev); else n_pass++;
        n_total++; if (unlock_event_o !== m_uev) $display("FAIL rnd_uev: cyc %0d got %0d want %0d", c, unlock_event_o, m_uev); else n_pass++;
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    acq_growth = 8'd4; acq_decay = 8'd2; lock_growth = 8'd1; lock_decay = 8'd8;
    lock_th = 8'd32; unlock_th = 8'd16; sat_lim = 8'd64;
`ifdef LOCK_CTRL_HOLDOVER_EN
    hold_cycles = 16'd10;
`endif
    test_reset();
    test_acquire();
    test_saturation();
    test_unlock();
`ifdef LOCK_CTRL_HOLDOVER_EN
    test_holdover_relock();
`endif
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
